spi_initiator: RTL and testbench
================================

// Module: spi_initiator
// PURPOSE
//  SPI controller that issues bus-access commands (rw_n, 17-bit addr, 8-bit data) over the Pi SPI protocol.
//  It is the initiator end of the link that spi_bridge answers.
//  Used for FPGA-to-FPGA bring-up, loopback self-test of spi_bridge, and co-simulation stimulus.
//  Accepts one command per valid/ready handshake and returns read data via a one-cycle response strobe.
// PARAMETERS
//  SCLK_DIV        2      clk_sys_i cycles per SCLK half-period (>=2)
//  CS_SETUP        2      clk_sys_i cycles from cs_n fall to first SCLK rise, and from last fall to cs_n rise
//  TIMEOUT_CYCLES  4096   ready-wait limit in clk_sys_i cycles (used only with SPI_INIT_TIMEOUT_EN)
// PORTS
//  clk_sys_i      in   1   system clock (16 MHz)
//  reset_ni       in   1   asynchronous, active-low reset
//  cmd_valid_i    in   1   command pending; cmd_* stable while high
//  cmd_ready_o    out  1   command accepted on cycle where valid && ready
//  cmd_rw_ni      in   1   1 = read, 0 = write
//  cmd_addr_i     in  17   target bus address
//  cmd_data_i     in   8   write data (ignored on read)
//  rsp_valid_o    out  1   one-cycle pulse: command complete
//  rsp_data_o     out  8   read data (0x00 after a write); held until next rsp_valid_o
//  timeout_o      out  1   one-cycle pulse with rsp_valid_o if ready-wait expired (tied 0 without macro)
//  spi_sclk_o     out  1   SPI clock, mode 0, idles low
//  spi_cs_no      out  1   chip select, active low
//  spi_tx_o       out  1   MOSI, MSB first
//  spi_rx_i       in   1   MISO, sampled on SCLK rise
//  spi_ready_ni   in   1   target-done, active low, asynchronous -> 2-flop synchroniser
// BEHAVIOUR
//  Reset values: cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, timeout_o=0, spi_sclk_o=0, spi_cs_no=1, spi_tx_o=0.
//  Reset is valid mid-frame: cs_n rises and SCLK drops in the same edge. Any in-flight command is discarded with no rsp_valid_o.
//  Frame on MOSI: byte0={rw_n,6'b0,addr[16]}, byte1=addr[15:8], byte2=addr[7:0], byte3=data (0x00 on read).
//  Totals: 32 SCLKs for a write, 40 for a read.
//  MOSI: bit 31 is driven at cs_n fall; each following bit changes on SCLK fall.
//  MISO: sampled on SCLK rise and used only in RD_SHIFT.
//  FSM:
//   IDLE: cmd_ready_o=1.
//   IDLE -(valid)-> SETUP: latch the command and load the 32-bit shift register.
//   SETUP -(CS_SETUP cycles)-> SHIFT.
//   SHIFT -(32nd SCLK fall)-> WAIT_RDY.
//   WAIT_RDY: SCLK held low, cs_n held low.
//   WAIT_RDY -(synced ready_n==0)-> RD_SHIFT if read, else HOLD.
//   RD_SHIFT -(8 SCLKs, MSB first)-> HOLD.
//   HOLD -(CS_SETUP cycles)-> cs_n=1 -> RELEASE.
//   RELEASE -(synced ready_n==1)-> DONE.
//   DONE: rsp_valid_o=1 for one cycle -> IDLE.
//  Latency: the earliest next acceptance is the cycle after DONE. No pipelining: one outstanding command.
//  cmd_ready_o is high only in IDLE. Asserting valid outside IDLE has no effect until IDLE.
//  spi_ready_ni already low at SETUP is a protocol error: it is ignored until WAIT_RDY, then honoured immediately.
//  Bit counter is 6 bits and saturates; it never wraps within a frame.
// CONFIGURATION
//  SPI_INIT_TIMEOUT_EN defined:
//   a 13-bit counter runs in WAIT_RDY and RELEASE.
//   Reaching TIMEOUT_CYCLES forces HOLD (from WAIT_RDY) or DONE (from RELEASE).
//   rsp_data_o=0xFF and timeout_o pulses with rsp_valid_o.
//  Not defined: WAIT_RDY and RELEASE wait indefinitely; timeout_o is constant 0.
// STRUCTURE
//  pet_spi_pkg: spi_init_state_t enum, FRAME_CMD_BITS=32, FRAME_RD_BITS=8, CMD_RW_BIT=7, CMD_A16_BIT=0.
//  Sub-module sync2 (2-flop synchroniser, async active-low reset to 1) for spi_ready_ni.
//  SCLK divider and bit counter stay in spi_initiator.
// TESTING
//  Write addr=0x1E80E data=0x5A:
//   MOSI bytes 01 E8 0E 5A, 32 SCLKs.
//   Model asserts ready -> rsp_valid_o pulse, rsp_data_o=0x00.
//  Read addr=0x0E80E, model returns 0xA5:
//   MOSI 80 E8 0E 00, then 8 more SCLKs.
//   rsp_data_o=0xA5, 40 SCLKs total.
//  Back-to-back: valid held high for two commands.
//   The second is accepted only the cycle after the first's DONE, and cs_n returns high between frames.
//  Reset pulled low at SCLK 17: cs_n=1, sclk=0 the same cycle.
//   No rsp_valid_o; after release, cmd_ready_o=1 on the first clock.
//  Model holds spi_ready_ni low across RELEASE for 100 cycles: rsp_valid_o is delayed until it rises (+2 sync cycles).
//  SPI_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=64, ready never asserted:
//   rsp_valid_o and timeout_o pulse, rsp_data_o=0xFF, cs_n=1.

Source files
------------

// File: rtl/pet_spi_pkg.sv
// Shared types and constants for the Pi SPI initiator: FSM state encoding,
// frame geometry and a helper that packs a command into the 32-bit MOSI frame.
package pet_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT_RDY,
    ST_RD_SHIFT,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } spi_init_state_t;

  localparam int FRAME_CMD_BITS = 32;
  localparam int FRAME_RD_BITS  = 8;
  localparam int CMD_RW_BIT     = 7;
  localparam int CMD_A16_BIT    = 0;

  // byte0 = {rw_n, 6'b0, addr[16]}, byte1/2 = addr[15:0], byte3 = data (0 on read)
  function automatic logic [FRAME_CMD_BITS-1:0] build_frame(input logic        rw_n,
                                                            input logic [16:0] addr,
                                                            input logic [7:0]  data);
    logic [7:0] cmd;
    cmd              = 8'h00;
    cmd[CMD_RW_BIT]  = rw_n;
    cmd[CMD_A16_BIT] = addr[16];
    return {cmd, addr[15:0], (rw_n ? 8'h00 : data)};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous active-low level; both stages
// reset to 1 so the synchronised signal reads "not ready" out of reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back capture stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_initiator.sv
// Pi SPI initiator: turns one rw/addr/data command into a mode-0 SPI frame,
// waits for the target's ready_n handshake, optionally shifts in a read byte,
// and reports completion with a one-cycle rsp_valid_o strobe.
// Optional feature: define SPI_INIT_TIMEOUT_EN to bound the ready waits.
module spi_initiator
  import pet_spi_pkg::*;
#(
  parameter int SCLK_DIV       = 2,
  parameter int CS_SETUP       = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_sys_i,
  input  logic        reset_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rw_ni,
  input  logic [16:0] cmd_addr_i,
  input  logic [7:0]  cmd_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        timeout_o,
  output logic        spi_sclk_o,
  output logic        spi_cs_no,
  output logic        spi_tx_o,
  input  logic        spi_rx_i,
  input  logic        spi_ready_ni
);

  spi_init_state_t state, state_next;

  logic                      cmd_ready;
  logic                      sclk;
  logic [7:0]                div_cnt;
  logic [7:0]                setup_cnt;
  logic [5:0]                bit_cnt;
  logic [FRAME_CMD_BITS-1:0] shift_reg;
  logic [FRAME_RD_BITS-1:0]  rx_reg;
  logic                      is_read;
  logic [7:0]                rsp_data;
  logic                      ready_n_sync;

  logic accept, shifting, div_tick, setup_done, sclk_fall, sclk_rise;
  logic last_cmd_fall, last_rd_fall;
  logic to_hit, timeout_evt, timed_out;

  sync2 u_ready_sync (
    .clk   (clk_sys_i),
    .rst_n (reset_ni),
    .d     (spi_ready_ni),
    .q     (ready_n_sync)
  );

  assign accept        = (state == ST_IDLE) && cmd_valid_i && cmd_ready;
  assign shifting      = (state == ST_SHIFT) || (state == ST_RD_SHIFT);
  assign div_tick      = (div_cnt == 8'(SCLK_DIV - 1));
  assign setup_done    = (setup_cnt == 8'(CS_SETUP - 1));
  assign sclk_fall     = shifting && div_tick && sclk;
  assign sclk_rise     = shifting && div_tick && !sclk;
  assign last_cmd_fall = sclk_fall && (bit_cnt == 6'(FRAME_CMD_BITS - 1));
  assign last_rd_fall  = sclk_fall && (bit_cnt == 6'(FRAME_CMD_BITS + FRAME_RD_BITS - 1));

`ifdef SPI_INIT_TIMEOUT_EN
  logic [12:0] to_cnt;

  assign to_hit      = (to_cnt == 13'(TIMEOUT_CYCLES - 1));
  // A timeout only counts if the awaited ready_n level has not arrived this cycle.
  assign timeout_evt = to_hit && (((state == ST_WAIT_RDY) && ready_n_sync) ||
                                  ((state == ST_RELEASE) && !ready_n_sync));

  // Ready-wait timer (restarts on every state change) and sticky timeout flag.
  always_ff @(posedge clk_sys_i or negedge reset_ni) begin
    if (!reset_ni) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state != state_next)
        to_cnt <= '0;
      else if ((state == ST_WAIT_RDY) || (state == ST_RELEASE))
        to_cnt <= to_cnt + 13'd1;
      if (state == ST_IDLE)
        timed_out <= 1'b0;
      else if (timeout_evt)
        timed_out <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign to_hit             = 1'b0;
  assign timeout_evt        = 1'b0;
  assign timed_out          = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge clk_sys_i or negedge reset_ni) begin
    if (!reset_ni) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept) state_next = ST_SETUP;
      ST_SETUP:    if (setup_done) state_next = ST_SHIFT;
      ST_SHIFT:    if (last_cmd_fall) state_next = ST_WAIT_RDY;
      ST_WAIT_RDY: if (!ready_n_sync) state_next = is_read ? ST_RD_SHIFT : ST_HOLD;
                   else if (to_hit)   state_next = ST_HOLD;
      ST_RD_SHIFT: if (last_rd_fall) state_next = ST_HOLD;
      ST_HOLD:     if (setup_done) state_next = ST_RELEASE;
      ST_RELEASE:  if (ready_n_sync || to_hit) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Datapath: SCLK divider, CS timing, shift/bit counters, read capture, response.
  always_ff @(posedge clk_sys_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cmd_ready <= 1'b0;
      sclk      <= 1'b0;
      div_cnt   <= '0;
      setup_cnt <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_reg    <= '0;
      is_read   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      // Registered so ready stays low through reset and the DONE cycle.
      cmd_ready <= (state_next == ST_IDLE);

      if (state != state_next)
        setup_cnt <= '0;
      else if ((state == ST_SETUP) || (state == ST_HOLD))
        setup_cnt <= setup_cnt + 8'd1;

      // First SCLK rise coincides with the end of the CS setup interval.
      if ((state == ST_SETUP) && setup_done) begin
        sclk    <= 1'b1;
        div_cnt <= '0;
      end else if (shifting) begin
        if (div_tick) begin
          sclk    <= ~sclk;
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end else begin
        sclk    <= 1'b0;
        div_cnt <= '0;
      end

      if (accept) begin
        shift_reg <= build_frame(cmd_rw_ni, cmd_addr_i, cmd_data_i);
        is_read   <= cmd_rw_ni;
        bit_cnt   <= '0;
      end else if (sclk_fall) begin
        shift_reg <= {shift_reg[FRAME_CMD_BITS-2:0], 1'b0};
        if (bit_cnt != 6'h3F) bit_cnt <= bit_cnt + 6'd1;
      end

      if (sclk_rise && (state == ST_RD_SHIFT))
        rx_reg <= {rx_reg[FRAME_RD_BITS-2:0], spi_rx_i};

      if ((state_next == ST_DONE) && (state != ST_DONE))
        rsp_data <= (timed_out || timeout_evt) ? 8'hFF : (is_read ? rx_reg : 8'h00);
    end
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    cmd_ready_o = cmd_ready;
    rsp_valid_o = (state == ST_DONE);
    rsp_data_o  = rsp_data;
    timeout_o   = (state == ST_DONE) && timed_out;
    spi_sclk_o  = sclk;
    spi_cs_no   = (state == ST_IDLE) || (state == ST_RELEASE) || (state == ST_DONE);
    spi_tx_o    = shift_reg[FRAME_CMD_BITS-1];
  end

endmodule

// File: tb/tb_spi_initiator.sv
// Bench for spi_initiator: table of commands with hand-computed MOSI frames,
// SCLK counts and responses, against a small SPI target model; plus
// back-to-back, mid-frame reset, long ready-release and (with
// SPI_INIT_TIMEOUT_EN) timeout sequences.
module tb_spi_initiator;

`ifdef SPI_INIT_TIMEOUT_EN
  localparam int TB_TIMEOUT = 64;
  localparam int HOLD_TEST  = 30;
`else
  localparam int TB_TIMEOUT = 4096;
  localparam int HOLD_TEST  = 100;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw_n = 1'b0;
  logic [16:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_ready_o, rsp_valid_o, timeout_o, spi_sclk_o, spi_cs_no, spi_tx_o;
  logic [7:0]  rsp_data_o;
  logic        spi_rx = 1'b0;
  logic        spi_ready_n = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_initiator #(.SCLK_DIV(2), .CS_SETUP(2), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_sys_i    (clk),
    .reset_ni     (reset_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_rw_ni    (cmd_rw_n),
    .cmd_addr_i   (cmd_addr),
    .cmd_data_i   (cmd_data),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .timeout_o    (timeout_o),
    .spi_sclk_o   (spi_sclk_o),
    .spi_cs_no    (spi_cs_no),
    .spi_tx_o     (spi_tx_o),
    .spi_rx_i     (spi_rx),
    .spi_ready_ni (spi_ready_n)
  );

  // ---------------- SPI target model (sampled on the falling clk edge) ----------------
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  int          sclk_cnt = 0;
  logic [39:0] mosi_sr = '0;
  int          phase = 3;
  int          hold_cnt = 0;
  logic [7:0]  miso_sr = '0;
  logic        model_rdy_en = 1'b1;
  int          model_release_hold = 0;
  logic [7:0]  model_rd_byte = '0;

  always @(negedge clk) begin
    cs_prev   <= spi_cs_no;
    sclk_prev <= spi_sclk_o;
    if (!spi_cs_no && cs_prev) begin
      sclk_cnt <= 0;
      mosi_sr  <= '0;
      phase    <= 0;
    end else begin
      if (!spi_cs_no && spi_sclk_o && !sclk_prev) begin
        sclk_cnt <= sclk_cnt + 1;
        mosi_sr  <= {mosi_sr[38:0], spi_tx_o};
      end
      case (phase)
        0: if (!spi_cs_no && sclk_cnt == 32 && !spi_sclk_o && model_rdy_en) begin
             spi_ready_n <= 1'b0;
             spi_rx      <= model_rd_byte[7];
             miso_sr     <= {model_rd_byte[6:0], 1'b0};
             phase       <= 1;
           end
        1: if (spi_cs_no) begin
             hold_cnt <= 0;
             phase    <= 2;
           end else if (!spi_sclk_o && sclk_prev && sclk_cnt >= 33) begin
             spi_rx  <= miso_sr[7];
             miso_sr <= {miso_sr[6:0], 1'b0};
           end
        2: if (hold_cnt >= model_release_hold) begin
             spi_ready_n <= 1'b1;
             phase       <= 3;
           end else begin
             hold_cnt <= hold_cnt + 1;
           end
        default: ;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rw_n;
    logic [16:0] addr;
    logic [7:0]  data;
    logic [7:0]  rd_byte;
    logic [31:0] exp_mosi;
    int          exp_sclks;
    logic [7:0]  exp_rsp;
  } vec_t;

  vec_t vecs[5];

  // Issue one command and check the whole transaction against the vector.
  task automatic run_cmd(input vec_t v, input int hold, input bit keep_valid, input bit exp_to,
                         input string tag, output int wait_cyc, output int rel_lat);
    int          cyc;
    int          cs_rise;
    int          ready_seen;
    bit          got;
    logic [7:0]  rsp_d;
    logic        to_v;
    logic        cs_v;
    logic [39:0] exp40;
    model_rd_byte      = v.rd_byte;
    model_release_hold = hold;
    cmd_rw_n  = v.rw_n;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    wait_cyc  = 0;
    rel_lat   = -1;
    while (!cmd_ready_o && wait_cyc < 100) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk({tag, " accept"}, cmd_ready_o, 1'b1);
    @(posedge clk); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    chk({tag, " ready_drop"}, cmd_ready_o, 1'b0);
    got = 0; cs_rise = -1; ready_seen = 0; cyc = 0;
    rsp_d = '0; to_v = 1'b0; cs_v = 1'b0;
    while (!got && cyc < 3000) begin
      if (cmd_ready_o) ready_seen++;
      if (spi_cs_no && cs_rise < 0) cs_rise = cyc;
      if (rsp_valid_o) begin
        got   = 1;
        rsp_d = rsp_data_o;
        to_v  = timeout_o;
        cs_v  = spi_cs_no;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    exp40 = (v.exp_sclks == 40) ? {v.exp_mosi, 8'h00} : {8'h00, v.exp_mosi};
    chk({tag, " rsp_seen"}, got, 1'b1);
    chk({tag, " rsp_data"}, rsp_d, exp_to ? 8'hFF : v.exp_rsp);
    chk({tag, " timeout"}, to_v, exp_to);
    chk({tag, " cs_high_at_rsp"}, cs_v, 1'b1);
    chk({tag, " no_ready_midframe"}, ready_seen, 0);
    chk({tag, " mosi"}, mosi_sr, exp40);
    chk({tag, " sclks"}, sclk_cnt, v.exp_sclks);
    if (got) rel_lat = cyc - cs_rise;
    @(posedge clk); #1;
    chk({tag, " rsp_pulse_end"}, rsp_valid_o, 1'b0);
    chk({tag, " ready_after_done"}, cmd_ready_o, 1'b1);
    $display("[TB] %s rw_n=%0b addr=%05h data=%02h -> rsp=%02h to=%0b mosi=%010h sclks=%0d",
             tag, v.rw_n, v.addr, v.data, rsp_d, to_v, mosi_sr, sclk_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, w2, lat2, n, rsp_cnt;
    //          rw    addr       data   rd_byte  exp_mosi       sclks  rsp
    vecs[0] = '{1'b0, 17'h1E80E, 8'h5A, 8'h00, 32'h01E80E5A, 32, 8'h00};
    vecs[1] = '{1'b1, 17'h0E80E, 8'h77, 8'hA5, 32'h80E80E00, 40, 8'hA5};
    vecs[2] = '{1'b0, 17'h00000, 8'hFF, 8'h00, 32'h000000FF, 32, 8'h00};
    vecs[3] = '{1'b1, 17'h1FFFF, 8'h00, 8'h3C, 32'h81FFFF00, 40, 8'h3C};
    vecs[4] = '{1'b0, 17'h12345, 8'h81, 8'h00, 32'h01234581, 32, 8'h00};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("reset cmd_ready", cmd_ready_o, 1'b0);
    chk("reset rsp_valid", rsp_valid_o, 1'b0);
    chk("reset rsp_data", rsp_data_o, 8'h00);
    chk("reset timeout", timeout_o, 1'b0);
    chk("reset sclk", spi_sclk_o, 1'b0);
    chk("reset cs_n", spi_cs_no, 1'b1);
    chk("reset tx", spi_tx_o, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset ready", cmd_ready_o, 1'b1);

    // Table-driven commands.
    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i], 0, 1'b0, 1'b0, $sformatf("vec%0d", i), w, lat);
      chk($sformatf("vec%0d release_latency", i), (lat >= 3 && lat <= 5), 1'b1);
    end

    // Back-to-back with valid held high across both commands.
    run_cmd(vecs[0], 0, 1'b1, 1'b0, "b2b_first", w, lat);
    run_cmd(vecs[1], 0, 1'b0, 1'b0, "b2b_second", w2, lat2);
    chk("b2b second accepted right after DONE", w2, 0);

    // Target keeps ready_n low across RELEASE.
    run_cmd(vecs[4], HOLD_TEST, 1'b0, 1'b0, "long_release", w, lat);
    chk("long_release latency", (lat >= HOLD_TEST + 3 && lat <= HOLD_TEST + 5), 1'b1);
    $display("[TB] long_release hold=%0d latency=%0d", HOLD_TEST, lat);

    // Reset asserted mid-frame around SCLK 17.
    cmd_rw_n = vecs[0].rw_n; cmd_addr = vecs[0].addr; cmd_data = vecs[0].data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready_o && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!(sclk_cnt >= 17 && spi_sclk_o) && n < 2000) begin @(posedge clk); #1; n++; end
    chk("midreset reached sclk17", (sclk_cnt == 17 && spi_sclk_o && !spi_cs_no), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset cs_n", spi_cs_no, 1'b1);
    chk("midreset sclk", spi_sclk_o, 1'b0);
    chk("midreset cmd_ready", cmd_ready_o, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset ready first clock", cmd_ready_o, 1'b1);
    rsp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_o || !spi_cs_no) rsp_cnt++;
      @(posedge clk); #1;
    end
    chk("midreset no rsp / idle bus", rsp_cnt, 0);
    $display("[TB] midreset cs_n=%0b sclk=%0b ready=%0b", spi_cs_no, spi_sclk_o, cmd_ready_o);
    run_cmd(vecs[3], 0, 1'b0, 1'b0, "after_reset", w, lat);

`ifdef SPI_INIT_TIMEOUT_EN
    // Target never answers: the ready wait must time out.
    model_rdy_en = 1'b0;
    run_cmd(vecs[0], 0, 1'b0, 1'b1, "timeout", w, lat);
    model_rdy_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
